matrag_chirp_top: RTL and testbench

Top-level tile of a linear-chirp tone generator. A direct digital synthesis (DDS) phase accumulator produces a square wave. Its frequency word is swept linearly between two parameterised bounds at a pin-programmable rate and step, either up or down, once or repeatedly. It sits directly on the standard tile pin interface; all bidirectional pins are inputs.

---
 rtl/chirp_pkg.sv | 26 ++
 rtl/chirp_dds.sv | 43 ++++
 rtl/matrag_chirp_top.sv | 148 ++++++++++++++
 tb/tb_matrag_chirp_top.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/chirp_pkg.sv
// Shared types and constants for the linear-chirp tone generator tile.
// State encoding, default sweep parameters and pin-bit positions.
package chirp_pkg;

  localparam int ACC_W_D = 24;
  localparam int FREQ_W_D = 16;
  localparam logic [15:0] F_MIN_D = 16'h0100;
  localparam logic [15:0] F_MAX_D = 16'h4000;

  localparam int UI_RUN = 0;
  localparam int UI_RPT = 1;
  localparam int UI_DOWN = 2;
  localparam int UI_E_LO = 4;

  localparam int UO_SQ = 0;
  localparam int UO_BUSY = 1;
  localparam int UO_DONE = 2;
  localparam int UO_F_LO = 3;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    HOLD
  } state_e;

endpackage

// File: rtl/chirp_dds.sv
// DDS phase accumulator; clear wins over accumulate.
// square is the accumulator MSB.
module chirp_dds
  import chirp_pkg::*;
#(
  parameter int ACC_W = ACC_W_D,
  parameter int FREQ_W = FREQ_W_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [FREQ_W-1:0] freq,
  output logic [ACC_W-1:0]  phase,
  output logic              square
);

  logic [ACC_W-1:0] phase_q;
  logic [ACC_W-1:0] phase_d;

  // next phase: clear, accumulate, or hold
  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = phase_q + ACC_W'(freq);
    end
  end

  // phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
  assign square = phase_q[ACC_W-1];

endmodule

// File: rtl/matrag_chirp_top.sv
// Chirp generator tile: FSM, prescaler, sweep arithmetic, pins.
// CHIRP_TRI_OUT_EN puts a phase triangle on uo_out[7:3].
module matrag_chirp_top
  import chirp_pkg::*;
#(
  parameter int ACC_W = ACC_W_D,
  parameter int FREQ_W = FREQ_W_D,
  parameter logic [FREQ_W-1:0] F_MIN = F_MIN_D,
  parameter logic [FREQ_W-1:0] F_MAX = F_MAX_D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [15:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic busy_q, busy_d;
  logic wrap_q, wrap_d;

  logic go, rpt, down, tick;
  logic [3:0] e;
  logic [FREQ_W-1:0] s_w, start;
  logic [15:0] mask;
  logic [FREQ_W:0] up_sum, dn_lim;
  logic hit_up, hit_dn;
  logic [ACC_W-1:0] phase;
  logic square;
  logic [4:0] hi_bits;

  assign go = ena & ui_in[UI_RUN];
  assign rpt = ui_in[UI_RPT];
  assign down = ui_in[UI_DOWN];
  assign e = ui_in[UI_E_LO +: 4];
  assign s_w = FREQ_W'(uio_in);
  assign start = down ? F_MAX : F_MIN;
  assign mask = 16'((17'd1 << e) - 17'd1);
  assign tick = (cnt_q == mask);

  assign up_sum = {1'b0, freq_q} + {1'b0, s_w};
  assign dn_lim = {1'b0, F_MIN} + {1'b0, s_w};
  assign hit_up = (s_w != '0) && (up_sum >= {1'b0, F_MAX});
  assign hit_dn = (s_w != '0) && ({1'b0, freq_q} <= dn_lim);

  // FSM next state, prescaler and sweep update
  always_comb begin
    state_d = state_q;
    freq_d = freq_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    wrap_d = wrap_q;
    if (!go) begin
      state_d = IDLE;
      freq_d = start;
      cnt_d = '0;
      wrap_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SWEEP;
          freq_d = start;
          cnt_d = '0;
          wrap_d = 1'b0;
        end
        SWEEP: begin
          cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
          if (tick) begin
            if (wrap_q) begin
              wrap_d = 1'b0;
              if (rpt) freq_d = start;
              else state_d = HOLD;
            end else if (down ? hit_dn : hit_up) begin
              freq_d = down ? F_MIN : F_MAX;
              done_d = 1'b1;
              if (rpt) wrap_d = 1'b1;
              else state_d = HOLD;
            end else begin
              freq_d = down ? freq_q - s_w : freq_q + s_w;
            end
          end
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_d = (state_d == SWEEP);

  // control and sweep registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      freq_q <= F_MIN;
      cnt_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_q <= freq_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      busy_q <= busy_d;
      wrap_q <= wrap_d;
    end
  end

  chirp_dds #(
    .ACC_W (ACC_W),
    .FREQ_W(FREQ_W)
  ) u_dds (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!go || (state_q == IDLE)),
    .en    (state_q != IDLE),
    .freq  (freq_q),
    .phase (phase),
    .square(square)
  );

`ifdef CHIRP_TRI_OUT_EN
  assign hi_bits = phase[ACC_W-2 -: 5] ^ {5{phase[ACC_W-1]}};
  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in[3], freq_q[FREQ_W-6:0]};
`else
  assign hi_bits = freq_q[FREQ_W-1 -: 5];
  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in[3], phase[ACC_W-2:0]};
`endif

  assign uo_out[UO_SQ] = square;
  assign uo_out[UO_BUSY] = busy_q;
  assign uo_out[UO_DONE] = done_q;
  assign uo_out[7:UO_F_LO] = hi_bits;
  assign uio_out = 8'h00;
  assign uio_oe = 8'h00;

endmodule

// File: tb/tb_matrag_chirp_top.sv
// Directed bench for matrag_chirp_top with an expected-value queue.
// Checks reset, fixed tone, up/down/repeat sweeps, abort and reset.
module tb_matrag_chirp_top;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    string tag;
    logic [7:0] val;
  } exp_t;

  exp_t sbq[$];
  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  matrag_chirp_top dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  function automatic logic [7:0] pack(input int f, input bit dn,
                                      input bit bz);
    logic [15:0] fw;
    fw = 16'(f);
    return {fw[15:11], dn, bz, 1'b0};
  endfunction

  task automatic set_in(input bit run, input bit rpt, input bit dn,
                        input int e, input int s);
    logic [3:0] e4;
    e4 = 4'(e);
    ui_in = {e4, 1'b0, dn, rpt, run};
    uio_in = 8'(s);
  endtask

  task automatic sb_check();
    exp_t x;
    if (sbq.size() == 0) begin
      total++;
      $error("FAIL sb_underflow observed=empty expected=entry");
    end else begin
      x = sbq.pop_front();
      chk(x.tag, {24'd0, uo_out & 8'hFE}, {24'd0, x.val});
    end
  endtask

  initial begin
    int bad;
    int per;
    int f;
    int m;
    bit prev;
    bit found;

    rst_n = 1'b0;
    ena = 1'b1;
    set_in(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uo", {24'd0, uo_out}, 32'h00);
    chk("rst_oe", {24'd0, uio_oe}, 32'h00);
    chk("rst_uio", {24'd0, uio_out}, 32'h00);

    set_in(0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    step();
    chk("idle_uo", {24'd0, uo_out}, 32'h00);

    set_in(1, 0, 0, 0, 0);
    step();
    chk("tone_start", {24'd0, uo_out}, 32'h02);
    bad = 0;
    for (int n = 1; n <= 32767; n++) begin
      step();
      if (uo_out[7:1] !== 7'h01) bad++;
    end
    chk("tone_sq_low", {31'd0, uo_out[0]}, 32'd0);
    chk("tone_flags", bad, 0);
    step();
    chk("tone_sq_high", {24'd0, uo_out}, 32'h03);

    set_in(0, 0, 0, 0, 0);
    step();
    chk("abort_run", {24'd0, uo_out}, 32'h00);

    set_in(1, 0, 0, 0, 'h40);
    for (int i = 1; i <= 255; i++) begin
      if (i < 252) f = 'h100 + i * 'h40;
      else f = 'h4000;
      sbq.push_back('{"up_sweep", pack(f, i == 252, i < 252)});
    end
    step();
    chk("up_start", {24'd0, uo_out & 8'hFE}, 32'h02);
    for (int i = 1; i <= 255; i++) begin
      step();
      sb_check();
    end

    found = 1'b0;
    per = 0;
    prev = uo_out[0];
    for (int n = 0; n < 2000 && !found; n++) begin
      step();
      if (!prev && uo_out[0]) found = 1'b1;
      prev = uo_out[0];
    end
    if (found) begin
      found = 1'b0;
      for (int n = 1; n < 2000 && !found; n++) begin
        step();
        if (!prev && uo_out[0]) begin
          found = 1'b1;
          per = n;
        end
        prev = uo_out[0];
      end
    end
    chk("hold_period", per, 1024);

    set_in(0, 0, 1, 0, 0);
    step();
    chk("idle_down", {24'd0, uo_out}, 32'h40);

    set_in(1, 0, 1, 2, 'h80);
    for (int i = 1; i <= 508; i++) begin
      if (i <= 504) f = 'h4000 - (i / 4) * 'h80;
      else f = 'h100;
      sbq.push_back('{"dn_sweep", pack(f, i == 504, i < 504)});
    end
    step();
    chk("dn_start", {24'd0, uo_out & 8'hFE}, 32'h42);
    for (int i = 1; i <= 508; i++) begin
      step();
      sb_check();
    end

    set_in(0, 0, 0, 0, 0);
    step();
    set_in(1, 1, 0, 0, 'h40);
    for (int i = 1; i <= 510; i++) begin
      m = ((i - 1) % 253) + 1;
      if (m == 253) f = 'h100;
      else if (m == 252) f = 'h4000;
      else f = 'h100 + m * 'h40;
      sbq.push_back('{"rpt_sweep", pack(f, m == 252, 1'b1)});
    end
    step();
    chk("rpt_start", {24'd0, uo_out & 8'hFE}, 32'h02);
    for (int i = 1; i <= 510; i++) begin
      step();
      sb_check();
    end

    ena = 1'b0;
    step();
    chk("abort_ena", {24'd0, uo_out}, 32'h00);
    ena = 1'b1;
    step();
    chk("restart", {24'd0, uo_out}, 32'h02);
    repeat (300) step();
    chk("restart_busy", {31'd0, uo_out[1]}, 32'd1);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid", {24'd0, uo_out}, 32'h00);
    chk("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
